// File: rtl/load_sequencer_pkg.sv
// Shared types for the load sequencer: FSM state encoding, data width and
// the queued entry layout {hold, data}.
package load_sequencer_pkg;

    localparam int unsigned DATA_W     = 4;
    // Stored hold field width; the top-level HOLD_W must not exceed this.
    localparam int unsigned HOLD_MAX_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic [HOLD_MAX_W-1:0] hold;
        logic [DATA_W-1:0]     data;
    } entry_t;

endpackage

// File: rtl/load_seq_fifo.sv
// Synchronous entry FIFO for the load sequencer.
// Ports:
//   clk, rst      rising-edge clock, synchronous active-low reset
//   push_i        write wdata_i (ignored when full or flushing)
//   pop_i         advance read pointer (ignored when empty or flushing)
//   flush_i       empty the FIFO; overrides push and pop
//   wdata_i       entry to write
//   rdata_c       head entry (combinational read)
//   level_o       registered occupancy, 0..DEPTH
//   full_c        level_o == DEPTH
//   empty_c       level_o == 0
module load_seq_fifo
    import load_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  entry_t                 wdata_i,
    output entry_t                 rdata_c,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_c,
    output logic                   empty_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               do_push;
    logic               do_pop;

    assign full_c  = (level_q == LVL_W'(DEPTH));
    assign empty_c = (level_q == '0);
    assign do_push = rst && push_i && !full_c && !flush_i;
    assign do_pop  = rst && pop_i && !empty_c && !flush_i;
    assign rdata_c = mem_q[rptr_q];
    assign level_o = level_q;

    // Pointer/level update; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PTR_W'(1);
            if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage array, no reset needed: contents are only read when level_q != 0.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/load_sequencer.sv
// Load sequencer: queues {hold, data} entries and replays each one as a
// single-cycle load strobe to a downstream 4-bit counter, followed by
// 'hold' idle cycles before the next entry is issued.
// Ports:
//   clk, rst    rising-edge clock, synchronous active-low reset
//   in_valid    producer offers {in_hold, in_data}
//   in_ready    entry accepted this cycle if in_valid (combinational)
//   in_data     preset value for the downstream counter
//   in_hold     idle cycles after this entry's load pulse
//   flush       drop queued entries and abort the current hold
//   load        registered load strobe
//   data        registered preset value, holds the last loaded value
//   busy        FSM not IDLE or FIFO non-empty
//   level       FIFO occupancy
module load_sequencer
    import load_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned HOLD_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [HOLD_W-1:0]      in_hold,
    input  logic                   flush,
    output logic                   load,
    output logic [DATA_W-1:0]      data,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    state_t                 state_q, state_d;
    logic [HOLD_MAX_W-1:0]  cnt_q, cnt_d;
    logic                   load_q, load_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   advance;
    logic                   pop;
    logic                   push;
    entry_t                 wr_entry;
    entry_t                 head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [LVL_W-1:0]       fifo_level;

    assign in_ready      = rst && !fifo_full && !flush;
    assign push          = in_valid && in_ready;
    assign wr_entry.hold = HOLD_MAX_W'(in_hold);
    assign wr_entry.data = in_data;

    load_seq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (wr_entry),
        .rdata_c (head),
        .level_o (fifo_level),
        .full_c  (fifo_full),
        .empty_c (fifo_empty)
    );

    // Next-state logic; 'advance' marks the cycle where the next entry may issue.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_d  = 1'b0;
        data_d  = data_q;
        advance = 1'b0;
        pop     = 1'b0;

        case (state_q)
            IDLE: advance = 1'b1;
            LOAD: begin
                if (cnt_q != '0) state_d = HOLD;
                else             advance = 1'b1;
            end
            HOLD: begin
                if (cnt_q == HOLD_MAX_W'(1)) advance = 1'b1;
                else                         cnt_d   = cnt_q - HOLD_MAX_W'(1);
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if (!fifo_empty) begin
                pop     = 1'b1;
                state_d = LOAD;
                load_d  = 1'b1;
                data_d  = head.data;
                cnt_d   = head.hold;
            end else begin
                state_d = IDLE;
            end
        end

        // Flush wins over any pop; data keeps its last loaded value.
        if (flush) begin
            state_d = IDLE;
            load_d  = 1'b0;
            data_d  = data_q;
            cnt_d   = '0;
            pop     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            load_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            data_q  <= data_d;
        end
    end

    assign load  = load_q;
    assign data  = data_q;
    assign busy  = (state_q != IDLE) || (fifo_level != '0);
    assign level = fifo_level;

endmodule

// File: tb/tb_load_sequencer.sv
// Testbench for load_sequencer: directed vector table, hand-written corner
// sequences and random traffic, all checked against a timing-level model
// (entry queue plus "earliest next issue edge").
module tb_load_sequencer;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned HOLD_W = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [3:0] in_hold;
    logic       flush;
    logic       load;
    logic [3:0] data;
    logic       busy;
    logic [2:0] level;

    always #5 clk = ~clk;

    load_sequencer #(
        .DEPTH  (DEPTH),
        .HOLD_W (HOLD_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_hold  (in_hold),
        .flush    (flush),
        .load     (load),
        .data     (data),
        .busy     (busy),
        .level    (level)
    );

    typedef struct {
        logic [3:0] d;
        logic [3:0] h;
    } ment_t;

    typedef struct {
        logic       r;
        logic       v;
        logic [3:0] d;
        logic [3:0] h;
        logic       f;
        logic       el;
        logic [3:0] ed;
        logic       eb;
        logic [2:0] elv;
    } vec_t;

    int     n_checks;
    int     n_fail;
    longint edge_n;
    longint free_edge;
    ment_t  q[$];
    logic   m_load;
    logic [3:0] m_data;
    logic   m_busy;
    vec_t   tbl [13];
    logic   saw_full;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    // One clock: drive inputs, check in_ready, advance model, check outputs.
    task automatic step(input logic r, input logic v, input logic [3:0] d,
                        input logic [3:0] h, input logic f);
        logic  exp_rdy;
        ment_t ent;
        rst      = r;
        in_valid = v;
        in_data  = d;
        in_hold  = h;
        flush    = f;
        #1;
        exp_rdy = r && (q.size() < DEPTH) && !f;
        chk("in_ready", 8'(in_ready), 8'(exp_rdy));

        if (!r) begin
            q.delete();
            free_edge = edge_n;
            m_load    = 1'b0;
            m_data    = 4'h0;
        end else if (f) begin
            q.delete();
            free_edge = edge_n;
            m_load    = 1'b0;
        end else begin
            m_load = 1'b0;
            if (edge_n >= free_edge && q.size() != 0) begin
                ent       = q.pop_front();
                m_load    = 1'b1;
                m_data    = ent.d;
                free_edge = edge_n + 1 + longint'(ent.h);
            end
            if (v && exp_rdy) begin
                ent.d = d;
                ent.h = h;
                q.push_back(ent);
            end
        end
        m_busy = (edge_n < free_edge) || (q.size() != 0);

        @(posedge clk);
        #1;
        chk("load",  8'(load),  8'(m_load));
        chk("data",  8'(data),  8'(m_data));
        chk("busy",  8'(busy),  8'(m_busy));
        chk("level", 8'(level), 8'(q.size()));
        edge_n++;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        edge_n    = 0;
        free_edge = 0;
        m_load    = 1'b0;
        m_data    = 4'h0;
        m_busy    = 1'b0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        in_hold   = 4'h0;
        flush     = 1'b0;

        // r, v, d, h, f  |  load, data, busy, level (after the edge)
        tbl[0]  = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0};
        tbl[1]  = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0};
        tbl[2]  = '{1'b1, 1'b1, 4'h3, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 3'd1};
        tbl[3]  = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h3, 1'b1, 3'd0};
        tbl[4]  = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h3, 1'b0, 3'd0};
        tbl[5]  = '{1'b1, 1'b1, 4'h3, 4'h2, 1'b0, 1'b0, 4'h3, 1'b1, 3'd1};
        tbl[6]  = '{1'b1, 1'b1, 4'hC, 4'h0, 1'b0, 1'b1, 4'h3, 1'b1, 3'd1};
        tbl[7]  = '{1'b1, 1'b1, 4'hB, 4'h1, 1'b0, 1'b0, 4'h3, 1'b1, 3'd2};
        tbl[8]  = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h3, 1'b1, 3'd2};
        tbl[9]  = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'hC, 1'b1, 3'd1};
        tbl[10] = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'hB, 1'b1, 3'd0};
        tbl[11] = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'hB, 1'b1, 3'd0};
        tbl[12] = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'hB, 1'b0, 3'd0};

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].h, tbl[i].f);
            chk("tbl_load",  8'(load),  8'(tbl[i].el));
            chk("tbl_data",  8'(data),  8'(tbl[i].ed));
            chk("tbl_busy",  8'(busy),  8'(tbl[i].eb));
            chk("tbl_level", 8'(level), 8'(tbl[i].elv));
        end

        // Producer held valid with long holds: FIFO fills and back-pressures.
        saw_full = 1'b0;
        for (int i = 0; i < 80; i++) begin
            step(1'b1, 1'b1, 4'($urandom), 4'hF, 1'b0);
            if (level == 3'd4) saw_full = 1'b1;
        end
        chk("fill_to_depth", 8'(saw_full), 8'd1);
        step(1'b1, 1'b0, 4'h0, 4'h0, 1'b1);

        // Flush during HOLD with three entries queued.
        step(1'b1, 1'b1, 4'h1, 4'h3, 1'b0);
        step(1'b1, 1'b1, 4'h2, 4'h0, 1'b0);
        step(1'b1, 1'b1, 4'h3, 4'h0, 1'b0);
        step(1'b1, 1'b1, 4'h4, 4'h0, 1'b0);
        chk("pre_flush_level", 8'(level), 8'd3);
        step(1'b1, 1'b0, 4'h0, 4'h0, 1'b1);
        chk("flush_level", 8'(level), 8'd0);
        chk("flush_data",  8'(data),  8'h1);
        chk("flush_busy",  8'(busy),  8'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
            chk("flush_no_load", 8'(load), 8'd0);
        end

        // Reset mid-HOLD with two entries queued.
        step(1'b1, 1'b1, 4'h5, 4'h3, 1'b0);
        step(1'b1, 1'b1, 4'h6, 4'h0, 1'b0);
        step(1'b1, 1'b1, 4'h7, 4'h0, 1'b0);
        chk("pre_rst_level", 8'(level), 8'd2);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        chk("rst_outputs", {4'(load), data}, 8'h00);
        chk("rst_busy_level", {4'(busy), 1'b0, level}, 8'h00);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
            chk("rst_ready", 8'(in_ready), 8'd1);
            chk("rst_no_load", 8'(load), 8'd0);
        end

        // Simultaneous push and pop at level 2, through pointer wrap.
        step(1'b1, 1'b1, 4'h8, 4'h1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, 4'(i + 3), 4'h0, 1'b0);
            if (i >= 2) chk("same_cycle_level", 8'(level), 8'd2);
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 63) != 0),
                 1'($urandom_range(0, 1)),
                 4'($urandom),
                 4'($urandom_range(0, 3)),
                 1'($urandom_range(0, 31) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
